// File: rtl/path_delay_meter.sv
// rtl/path_delay_meter.sv - launch/capture delay meter for one spy chain; optional multi-trial averaging via PDM_AVG_EN
module path_delay_meter #(
    parameter int CNT_W         = 16,
    parameter int MAX_COUNT     = 1000,
    parameter int SETTLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int PATH_INV      = 0,
    parameter int LOG2_TRIALS   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             path_drive,
    input  logic             path_sense,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             settle_err,
    output logic [CNT_W-1:0] delay_cycles
`ifdef PDM_AVG_EN
    ,
    output logic [LOG2_TRIALS-1:0] trial_idx
`endif
);

    generate
        if (MAX_COUNT >= (2 ** CNT_W) || SYNC_STAGES < 2 || SETTLE_CYCLES < 1) begin : g_param_check
            $error("path_delay_meter: MAX_COUNT must fit CNT_W, SYNC_STAGES >= 2, SETTLE_CYCLES >= 1");
        end
    endgenerate

    localparam logic             INV         = (PATH_INV != 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LAUNCH,
        WAIT,
        DONE,
        TOUT
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sense_s;
    logic                   match;

    assign sense_s = sync[SYNC_STAGES-1];
    // The expected sense level is the drive level, flipped for an inverting chain.
    assign match   = (sense_s == (path_drive ^ INV));

`ifdef PDM_AVG_EN
    localparam int ACC_W = CNT_W + LOG2_TRIALS;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    assign acc_next = acc + {{LOG2_TRIALS{1'b0}}, cnt};
`endif

    // Bring the asynchronous chain output into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], path_sense};
        end
    end

    // Measurement sequencer: settle, launch one edge, count until the edge returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            path_drive   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            settle_err   <= 1'b0;
            delay_cycles <= '0;
            cnt          <= '0;
`ifdef PDM_AVG_EN
            acc          <= '0;
            trial_idx    <= '0;
`endif
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        busy       <= 1'b1;
                        settle_err <= 1'b0;
                        cnt        <= '0;
`ifdef PDM_AVG_EN
                        acc        <= '0;
                        trial_idx  <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        // A mismatch here means the chain had not settled; flag it but measure anyway.
                        if (!match) begin
                            settle_err <= 1'b1;
                        end
                        state <= LAUNCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LAUNCH: begin
                    path_drive <= ~path_drive;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // Match is tested before the limit so an edge arriving on the last count still counts.
                    if (match) begin
`ifdef PDM_AVG_EN
                        if (trial_idx == {LOG2_TRIALS{1'b1}}) begin
                            delay_cycles <= acc_next[ACC_W-1:LOG2_TRIALS];
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            trial_idx    <= '0;
                            state        <= DONE;
                        end else begin
                            acc       <= acc_next;
                            trial_idx <= trial_idx + LOG2_TRIALS'(1);
                            cnt       <= '0;
                            state     <= SETTLE;
                        end
`else
                        delay_cycles <= cnt;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
`endif
                    end else if (cnt == CNT_MAX) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
`ifdef PDM_AVG_EN
                        trial_idx <= '0;
`endif
                        state   <= TOUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                TOUT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
